lms7_rx_fe_sched: RTL and testbench
===================================

# lms7_rx_fe_sched

Timed command scheduler for the LMS7 RX frontend configuration port. It queues host-issued frontend commands (burster size/throttle, DSP0 config), each optionally tagged with an RX timestamp. It releases them in order on the frontend `fe_cmd_*` handshake once `ts_current` reaches the tag. It sits in the `in_sdr_clk` domain between the host register bridge and the RX framer/burster, so configuration changes land on exact sample boundaries.

## Interface
Parameters:
- `TS_BITS`, 30, width of the RX timestamp and command tag.
- `DEPTH_BITS`, 3, log2 of the queue depth (8 entries).

Ports:
- `in_sdr_clk` in 1: RX frontend clock; the only clock.
- `fe_reset_n` in 1: reset, asynchronous assert, active-low.
- `ts_current` in TS_BITS: current RX sample timestamp from the framer; monotonic, wraps.
- `sched_cmd_data` in 32: frontend command word; routed unchanged to `fe_cmd_data`.
- `sched_cmd_ts` in TS_BITS: release timestamp.
- `sched_cmd_timed` in 1: 1 = hold until the tag is due; 0 = release as soon as the command is at the head.
- `sched_cmd_valid` in 1 / `sched_cmd_ready` out 1: enqueue handshake.
- `sched_flush` in 1: synchronous queue clear.
- `fe_cmd_data` out 32 / `fe_cmd_valid` out 1 / `fe_cmd_ready` in 1: frontend command handshake.
- `sched_fill` out DEPTH_BITS+1: queued entry count, excluding the output register.
- `sched_late_cnt` out 8: count of timed commands released after their tag; saturating.
- `sched_busy` out 1: high when the queue is non-empty or `fe_cmd_valid` is high.

## Operation
- Reset (`fe_reset_n` low, async): queue empty; `fe_cmd_valid`=0, `fe_cmd_data`=0, `sched_fill`=0, `sched_late_cnt`=0, `sched_cmd_ready`=0, `sched_busy`=0.
- `sched_cmd_ready` = ~full & ~sched_flush (out of reset). When full there is no write-through, even if a pop happens in the same cycle.
- Queue: circular buffer of {data, ts, timed}, 2^DEPTH_BITS entries. Read/write pointers are DEPTH_BITS+1 wide; full/empty are decided by the extra pointer bit.
- Due test: diff = (ts_current - head_ts) mod 2^TS_BITS. The head is due when diff[TS_BITS-1]==0. This is wrap-safe; a tag up to 2^(TS_BITS-1)-1 ahead is treated as future.
- Release condition: head valid, (~head_timed | due), and output register free (`fe_cmd_valid`==0 or `fe_cmd_ready`==1). On release the head is popped into the output register and `fe_cmd_valid` is set.
- Late: a released timed command with diff != 0 increments `sched_late_cnt`, saturating at 255. The counter is cleared only by reset.
- Output register: `fe_cmd_data` is held stable while `fe_cmd_valid`=1 and `fe_cmd_ready`=0. `fe_cmd_valid` drops only after acceptance with no new release in the same cycle. Back-to-back releases are allowed with ready held high.
- Strict in-order: a non-due timed head blocks all entries behind it, including untimed ones.
- Flush: clears the queue pointers on the edge it is sampled. An enqueue in the same cycle is dropped (ready is low). A command already in the output register is still presented until accepted. `sched_late_cnt` is unaffected.
- Simultaneous push and pop when neither full nor empty: fill is unchanged.

## Timing
- Enqueue on edge E0. For an untimed command with an empty queue and a free output register, `fe_cmd_valid`=1 after E1. This is 1 cycle of latency.
- Timed command: first edge Ed at which the sampled `ts_current` makes the head due performs the release; `fe_cmd_valid`=1 after Ed.
- Due evaluation uses the registered head entry and the current `ts_current`. There is no additional pipeline stage.
- `sched_fill` updates on the same edge as the push/pop.
- Throughput: 1 command per cycle with `fe_cmd_ready` held high.

## Test plan
- Untimed burst: push 0x0000_01FF, 0x1000_0003, 0x0801_0402 with ready=1 → three `fe_cmd_valid` cycles in order, the first 1 cycle after the first enqueue. `sched_late_cnt`=0.
- Timed release: ts_current ramps from 100; push tag 120 → `fe_cmd_valid` rises exactly 1 cycle after ts_current=120 is sampled. Late count remains 0.
- Late and wrap: push tag 90 while ts_current=100 → immediate release, late_cnt=1. Set ts_current=2^30-4 and push tag 3 → held until ts_current wraps to 3.
- Head blocking and full: push timed tag 1000, then 8 untimed commands → ready=0 at fill=8 and nothing is released. At ts=1000 all 9 drain in order.
- Backpressure: hold `fe_cmd_ready`=0 for 5 cycles with 3 queued → data stable, no loss. Release ready → remaining commands go out back-to-back.
- Flush/reset mid-operation: flush with 4 queued and one presented → the presented one completes, fill=0. Assert fe_reset_n low mid-drain → all outputs go to reset values immediately (async).

Source files
------------

// File: rtl/lms7_rx_fe_sched.sv
// lms7_rx_fe_sched: in-order RX frontend command queue whose entries are released
// on the fe_cmd handshake once their RX timestamp tag is due (wrap-safe compare).
module lms7_rx_fe_sched #(
  parameter int TS_BITS    = 30,
  parameter int DEPTH_BITS = 3
) (
  input  logic                  in_sdr_clk,
  input  logic                  fe_reset_n,
  input  logic [TS_BITS-1:0]    ts_current,
  input  logic [31:0]           sched_cmd_data,
  input  logic [TS_BITS-1:0]    sched_cmd_ts,
  input  logic                  sched_cmd_timed,
  input  logic                  sched_cmd_valid,
  output logic                  sched_cmd_ready,
  input  logic                  sched_flush,
  output logic [31:0]           fe_cmd_data,
  output logic                  fe_cmd_valid,
  input  logic                  fe_cmd_ready,
  output logic [DEPTH_BITS:0]   sched_fill,
  output logic [7:0]            sched_late_cnt,
  output logic                  sched_busy
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] PTR_ONE  = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [DEPTH_BITS:0] PTR_ZERO = {(DEPTH_BITS+1){1'b0}};

  logic [31:0]         mem_data [DEPTH];
  logic [TS_BITS-1:0]  mem_ts   [DEPTH];
  logic [DEPTH-1:0]    mem_timed;
  logic [DEPTH_BITS:0] wr_ptr;
  logic [DEPTH_BITS:0] rd_ptr;
  logic                run;

  logic [DEPTH_BITS-1:0] wr_idx;
  logic [DEPTH_BITS-1:0] head_idx;
  logic [TS_BITS-1:0]    head_diff;
  logic                  head_timed;
  logic                  empty;
  logic                  full;
  logic                  out_free;
  logic                  push;
  logic                  pop;
  logic                  late_inc;

  function automatic logic tag_due(input logic [TS_BITS-1:0] diff);
    return ~diff[TS_BITS-1];
  endfunction

  assign wr_idx     = wr_ptr[DEPTH_BITS-1:0];
  assign head_idx   = rd_ptr[DEPTH_BITS-1:0];
  assign head_diff  = ts_current - mem_ts[head_idx];
  assign head_timed = mem_timed[head_idx];
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
                      (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);
  assign out_free   = ~fe_cmd_valid | fe_cmd_ready;

  // ready stays low until the first edge after reset so nothing is taken mid-reset
  assign sched_cmd_ready = run & ~full & ~sched_flush;
  assign push     = sched_cmd_valid & sched_cmd_ready;
  assign pop      = ~empty & ~sched_flush & (~head_timed | tag_due(head_diff)) & out_free;
  assign late_inc = pop & head_timed & (head_diff != {TS_BITS{1'b0}}) &
                    (sched_late_cnt != 8'hFF);

  assign sched_fill = wr_ptr - rd_ptr;
  assign sched_busy = ~empty | fe_cmd_valid;

  // Queue storage write port.
  always_ff @(posedge in_sdr_clk) begin
    if (push) begin
      mem_data[wr_idx]  <= sched_cmd_data;
      mem_ts[wr_idx]    <= sched_cmd_ts;
      mem_timed[wr_idx] <= sched_cmd_timed;
    end
  end

  // Queue pointers and post-reset enable.
  always_ff @(posedge in_sdr_clk or negedge fe_reset_n) begin
    if (!fe_reset_n) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (sched_flush) begin
        wr_ptr <= PTR_ZERO;
        rd_ptr <= PTR_ZERO;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Output register and saturating late counter.
  always_ff @(posedge in_sdr_clk or negedge fe_reset_n) begin
    if (!fe_reset_n) begin
      fe_cmd_data    <= 32'h0000_0000;
      fe_cmd_valid   <= 1'b0;
      sched_late_cnt <= 8'h00;
    end else begin
      if (pop) begin
        fe_cmd_data  <= mem_data[head_idx];
        fe_cmd_valid <= 1'b1;
      end else if (fe_cmd_ready) begin
        fe_cmd_valid <= 1'b0;
      end
      if (late_inc) sched_late_cnt <= sched_late_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_lms7_rx_fe_sched.sv
// Self-checking bench for lms7_rx_fe_sched: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based behavioural model.
module tb_lms7_rx_fe_sched;

  localparam longint TS_MOD = 64'sd1073741824;

  logic        in_sdr_clk = 1'b0;
  logic        fe_reset_n;
  logic [29:0] ts_current;
  logic [31:0] sched_cmd_data;
  logic [29:0] sched_cmd_ts;
  logic        sched_cmd_timed;
  logic        sched_cmd_valid;
  logic        sched_cmd_ready;
  logic        sched_flush;
  logic [31:0] fe_cmd_data;
  logic        fe_cmd_valid;
  logic        fe_cmd_ready;
  logic [3:0]  sched_fill;
  logic [7:0]  sched_late_cnt;
  logic        sched_busy;

  always #5 in_sdr_clk = ~in_sdr_clk;

  lms7_rx_fe_sched #(.TS_BITS(30), .DEPTH_BITS(3)) dut (
    .in_sdr_clk      (in_sdr_clk),
    .fe_reset_n      (fe_reset_n),
    .ts_current      (ts_current),
    .sched_cmd_data  (sched_cmd_data),
    .sched_cmd_ts    (sched_cmd_ts),
    .sched_cmd_timed (sched_cmd_timed),
    .sched_cmd_valid (sched_cmd_valid),
    .sched_cmd_ready (sched_cmd_ready),
    .sched_flush     (sched_flush),
    .fe_cmd_data     (fe_cmd_data),
    .fe_cmd_valid    (fe_cmd_valid),
    .fe_cmd_ready    (fe_cmd_ready),
    .sched_fill      (sched_fill),
    .sched_late_cnt  (sched_late_cnt),
    .sched_busy      (sched_busy)
  );

  typedef struct {
    logic [31:0] data;
    longint      ts;
    bit          timed;
  } ent_t;

  ent_t        mq[$];
  bit          m_run;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_late;
  bit          last_push;
  bit          exp_ready;
  logic        seen_ready;
  int          checks = 0;
  int          failures = 0;

  wire [45:0] act_vec = {fe_cmd_valid, fe_cmd_data, sched_fill, sched_late_cnt, sched_busy};

  function automatic logic [45:0] exp_vec();
    logic busy;
    busy = (mq.size() != 0) || m_valid;
    return {m_valid, m_data, 4'(mq.size()), 8'(m_late), busy};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_run = 1'b0; m_valid = 1'b0; m_data = 32'h0; m_late = 0; last_push = 1'b0;
  endtask

  // One clock cycle: sample ready before the edge, advance the model after it.
  task automatic tick();
    longint d;
    bit     rel, push, late_hit;
    ent_t   e;
    @(negedge in_sdr_clk);
    seen_ready = sched_cmd_ready;
    exp_ready  = m_run && (mq.size() < 8) && !sched_flush;
    push       = sched_cmd_valid && exp_ready;
    rel = 1'b0; late_hit = 1'b0;
    if (!sched_flush && mq.size() > 0 && (!m_valid || fe_cmd_ready)) begin
      d = (longint'(ts_current) - mq[0].ts + TS_MOD) % TS_MOD;
      if (!mq[0].timed || d < TS_MOD / 2) begin
        rel = 1'b1;
        late_hit = mq[0].timed && (d != 0);
      end
    end
    @(posedge in_sdr_clk);
    #1;
    if (rel) begin
      e = mq.pop_front();
      m_data = e.data; m_valid = 1'b1;
      if (late_hit && m_late < 255) m_late++;
    end else if (fe_cmd_ready) begin
      m_valid = 1'b0;
    end
    if (sched_flush) mq.delete();
    if (push) mq.push_back('{data: sched_cmd_data, ts: longint'(sched_cmd_ts), timed: sched_cmd_timed});
    last_push = push;
    m_run = 1'b1;
  endtask

  task automatic test_reset();
    fe_reset_n = 1'b0; ts_current = 30'd0; sched_cmd_data = 32'h0; sched_cmd_ts = 30'd0;
    sched_cmd_timed = 1'b0; sched_cmd_valid = 1'b0; sched_flush = 1'b0; fe_cmd_ready = 1'b1;
    model_reset();
    #1;
    checks++; if (act_vec !== 46'd0 || sched_cmd_ready !== 1'b0) begin failures++;
      $display("FAIL reset_outputs: got %h rdy %b want 0", act_vec, sched_cmd_ready); end
    repeat (3) @(posedge in_sdr_clk);
    #1;
    fe_reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (seen_ready !== exp_ready) begin failures++;
        $display("FAIL reset_ready: got %b want %b", seen_ready, exp_ready); end
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL reset_out: got %h want %h", act_vec, exp_vec()); end
    end
  endtask

  task automatic test_untimed_burst();
    logic [31:0] cmds [3];
    int idx = 0;
    cmds[0] = 32'h0000_01FF; cmds[1] = 32'h1000_0003; cmds[2] = 32'h0801_0402;
    fe_cmd_ready = 1'b1; sched_cmd_timed = 1'b0; ts_current = 30'd50;
    for (int k = 0; k < 8; k++) begin
      sched_cmd_valid = (idx < 3);
      if (idx < 3) sched_cmd_data = cmds[idx];
      tick();
      if (last_push) idx++;
      checks++; if (seen_ready !== exp_ready) begin failures++;
        $display("FAIL burst_ready: got %b want %b", seen_ready, exp_ready); end
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL burst_out: got %h want %h", act_vec, exp_vec()); end
      if (k == 0) begin
        checks++; if (fe_cmd_valid !== 1'b0) begin failures++;
          $display("FAIL burst_latency0: got %b want 0", fe_cmd_valid); end
      end
      if (k == 1) begin
        checks++; if (fe_cmd_valid !== 1'b1 || fe_cmd_data !== 32'h0000_01FF) begin failures++;
          $display("FAIL burst_first: got %b/%h want 1/000001ff", fe_cmd_valid, fe_cmd_data); end
      end
    end
    sched_cmd_valid = 1'b0;
    checks++; if (sched_late_cnt !== 8'd0) begin failures++;
      $display("FAIL burst_late: got %0d want 0", sched_late_cnt); end
  endtask

  task automatic test_timed_release();
    int first_k = -1;
    fe_cmd_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      ts_current = 30'(100 + k);
      sched_cmd_valid = (k == 0); sched_cmd_timed = 1'b1;
      sched_cmd_ts = 30'd120; sched_cmd_data = 32'h5A5A_0120;
      tick();
      if (fe_cmd_valid === 1'b1 && first_k < 0) first_k = k;
      checks++; if (seen_ready !== exp_ready) begin failures++;
        $display("FAIL timed_ready: got %b want %b", seen_ready, exp_ready); end
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL timed_out: got %h want %h", act_vec, exp_vec()); end
    end
    sched_cmd_valid = 1'b0;
    checks++; if (first_k !== 20) begin failures++;
      $display("FAIL timed_release_cycle: got %0d want 20", first_k); end
    checks++; if (sched_late_cnt !== 8'd0) begin failures++;
      $display("FAIL timed_late: got %0d want 0", sched_late_cnt); end
  endtask

  task automatic test_late_wrap();
    int first_k = -1;
    fe_cmd_ready = 1'b1; sched_cmd_timed = 1'b1; ts_current = 30'd100;
    for (int k = 0; k < 4; k++) begin
      sched_cmd_valid = (k == 0); sched_cmd_ts = 30'd90; sched_cmd_data = 32'hDEAD_0090;
      tick();
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL late_out: got %h want %h", act_vec, exp_vec()); end
    end
    checks++; if (sched_late_cnt !== 8'd1) begin failures++;
      $display("FAIL late_count: got %0d want 1", sched_late_cnt); end
    for (int k = 0; k < 12; k++) begin
      ts_current = 30'((TS_MOD - 4 + k) % TS_MOD);
      sched_cmd_valid = (k == 0); sched_cmd_ts = 30'd3; sched_cmd_data = 32'hBEEF_0003;
      tick();
      if (fe_cmd_valid === 1'b1 && first_k < 0) first_k = k;
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL wrap_out: got %h want %h", act_vec, exp_vec()); end
    end
    sched_cmd_valid = 1'b0;
    checks++; if (first_k !== 7) begin failures++;
      $display("FAIL wrap_release_cycle: got %0d want 7", first_k); end
    checks++; if (sched_late_cnt !== 8'd1) begin failures++;
      $display("FAIL wrap_late: got %0d want 1", sched_late_cnt); end
  endtask

  task automatic test_head_block_full();
    int idx = 0;
    int nvalid = 0;
    fe_cmd_ready = 1'b1; ts_current = 30'd500;
    for (int k = 0; k < 14; k++) begin
      sched_cmd_valid = (idx < 9);
      sched_cmd_timed = (idx == 0); sched_cmd_ts = 30'd1000;
      sched_cmd_data = 32'hB000_0000 + 32'(idx);
      tick();
      if (last_push) idx++;
      checks++; if (seen_ready !== exp_ready) begin failures++;
        $display("FAIL block_ready: got %b want %b", seen_ready, exp_ready); end
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL block_out: got %h want %h", act_vec, exp_vec()); end
    end
    checks++; if (sched_fill !== 4'd8 || sched_cmd_ready !== 1'b0 || fe_cmd_valid !== 1'b0) begin failures++;
      $display("FAIL block_full: got fill %0d rdy %b vld %b want 8/0/0", sched_fill, sched_cmd_ready, fe_cmd_valid); end
    ts_current = 30'd1000;
    for (int k = 0; k < 15; k++) begin
      sched_cmd_valid = (idx < 9);
      sched_cmd_timed = 1'b0; sched_cmd_data = 32'hB000_0000 + 32'(idx);
      tick();
      if (last_push) idx++;
      if (fe_cmd_valid === 1'b1) nvalid++;
      checks++; if (seen_ready !== exp_ready) begin failures++;
        $display("FAIL drain_ready: got %b want %b", seen_ready, exp_ready); end
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL drain_out: got %h want %h", act_vec, exp_vec()); end
    end
    sched_cmd_valid = 1'b0;
    checks++; if (nvalid !== 9) begin failures++;
      $display("FAIL drain_count: got %0d want 9", nvalid); end
  endtask

  task automatic test_backpressure();
    fe_cmd_ready = 1'b0; sched_cmd_timed = 1'b0;
    for (int k = 0; k < 14; k++) begin
      sched_cmd_valid = (k < 3); sched_cmd_data = 32'hC0DE_0000 + 32'(k);
      if (k == 8) fe_cmd_ready = 1'b1;
      tick();
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL bp_out: got %h want %h", act_vec, exp_vec()); end
      if (k >= 3 && k < 8) begin
        checks++; if (fe_cmd_valid !== 1'b1 || fe_cmd_data !== 32'hC0DE_0000) begin failures++;
          $display("FAIL bp_hold: got %b/%h want 1/c0de0000", fe_cmd_valid, fe_cmd_data); end
      end
    end
    sched_cmd_valid = 1'b0;
  endtask

  task automatic test_flush();
    fe_cmd_ready = 1'b0; sched_cmd_timed = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sched_cmd_valid = 1'b1; sched_cmd_data = 32'hF100_0000 + 32'(k);
      tick();
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL flush_fill: got %h want %h", act_vec, exp_vec()); end
    end
    sched_flush = 1'b1; sched_cmd_data = 32'hF1FF_FFFF;
    tick();
    checks++; if (seen_ready !== 1'b0) begin failures++;
      $display("FAIL flush_ready: got %b want 0", seen_ready); end
    checks++; if (sched_fill !== 4'd0 || fe_cmd_valid !== 1'b1 || fe_cmd_data !== 32'hF100_0000) begin failures++;
      $display("FAIL flush_state: got fill %0d vld %b data %h want 0/1/f1000000", sched_fill, fe_cmd_valid, fe_cmd_data); end
    sched_flush = 1'b0; sched_cmd_valid = 1'b0; fe_cmd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL flush_after: got %h want %h", act_vec, exp_vec()); end
    end
    checks++; if (sched_busy !== 1'b0) begin failures++;
      $display("FAIL flush_busy: got %b want 0", sched_busy); end
  endtask

  task automatic test_random();
    ts_current = 30'(TS_MOD - 200);
    for (int k = 0; k < 400; k++) begin
      fe_cmd_ready    = ($urandom_range(0, 3) != 0);
      sched_flush     = ($urandom_range(0, 63) == 0);
      sched_cmd_valid = $urandom_range(0, 1);
      sched_cmd_timed = $urandom_range(0, 1);
      sched_cmd_data  = $urandom;
      sched_cmd_ts    = 30'((longint'(ts_current) + TS_MOD + longint'($urandom_range(0, 90)) - 30) % TS_MOD);
      tick();
      checks++; if (seen_ready !== exp_ready) begin failures++;
        $display("FAIL rand_ready: cyc %0d got %b want %b", k, seen_ready, exp_ready); end
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL rand_out: cyc %0d got %h want %h", k, act_vec, exp_vec()); end
      ts_current = 30'((longint'(ts_current) + longint'($urandom_range(0, 2))) % TS_MOD);
    end
    sched_flush = 1'b0; sched_cmd_valid = 1'b0; fe_cmd_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    fe_cmd_ready = 1'b0; sched_cmd_timed = 1'b0; ts_current = 30'd7;
    for (int k = 0; k < 4; k++) begin
      sched_cmd_valid = 1'b1; sched_cmd_data = 32'hA5A5_0000 + 32'(k);
      tick();
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL ar_pre: got %h want %h", act_vec, exp_vec()); end
    end
    sched_cmd_valid = 1'b0;
    #2;
    fe_reset_n = 1'b0;
    #1;
    checks++; if (act_vec !== 46'd0 || sched_cmd_ready !== 1'b0) begin failures++;
      $display("FAIL async_reset: got %h rdy %b want 0", act_vec, sched_cmd_ready); end
    model_reset();
    @(posedge in_sdr_clk);
    #1;
    fe_reset_n = 1'b1; fe_cmd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sched_cmd_valid = (k >= 1 && k < 3); sched_cmd_data = 32'h7700_0000 + 32'(k);
      tick();
      checks++; if (seen_ready !== exp_ready) begin failures++;
        $display("FAIL ar_ready: got %b want %b", seen_ready, exp_ready); end
      checks++; if (act_vec !== exp_vec()) begin failures++;
        $display("FAIL ar_post: got %h want %h", act_vec, exp_vec()); end
    end
    sched_cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_untimed_burst();
    test_timed_release();
    test_late_wrap();
    test_head_block_full();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
